// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: command codes, state encodings
// and sizing helpers.
package spi_ram_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] WR_ADDR = 3'b000;
  localparam logic [CMD_W-1:0] WR_DATA = 3'b001;
  localparam logic [CMD_W-1:0] RD_ADDR = 3'b110;
  localparam logic [CMD_W-1:0] RD_DATA = 3'b111;

  // Per-frame states. GAP is owned by the sequencer, not the frame engine.
  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    CAPTURE,
    GAP
  } state_e;

  // Transaction-level phases of the top-level sequencer.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_FRAME,
    PH_GAP
  } phase_e;

  // Number of bits serialised on MOSI in one frame: command plus payload.
  function automatic int unsigned frame_bits(input int unsigned addr_size);
    return CMD_W + addr_size;
  endfunction

  // Counter width able to count 0 .. N-1 for the longest timed interval.
  function automatic int unsigned cnt_width(input int unsigned addr_size,
                                            input int unsigned rd_wait,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = frame_bits(addr_size);
    if (rd_wait > m) m = rd_wait;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/spi_ram_frame_engine.sv
// Executes one SPI frame: START, SHIFT of {cmd, payload}, and for read-data
// frames WAIT followed by CAPTURE of ADDR_SIZE bits from MISO.
module spi_ram_frame_engine
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CMD_W-1:0]     cmd_i,
  input  logic [ADDR_SIZE-1:0] payload_i,
  input  logic                 miso_i,
  output logic                 ss_n_o,
  output logic                 mosi_o,
  output logic                 done_o,
  output logic [ADDR_SIZE-1:0] rdata_o
);

  localparam int unsigned      FRAME_BITS = frame_bits(ADDR_SIZE);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(ADDR_SIZE - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [ADDR_SIZE-1:0]    rx_q, rx_d;
  logic                    rd_q, rd_d;
  logic [ADDR_SIZE-1:0]    cap_word;

  // Word as it will stand after this cycle's MISO sample.
  assign cap_word = {rx_q[ADDR_SIZE-2:0], miso_i};

  // Next-state logic for the frame sequencing, shift and capture registers.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = START;
          sh_d    = {cmd_i, payload_i};
          rd_d    = (cmd_i == RD_DATA);
        end
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        sh_d = {sh_q[FRAME_BITS-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (!rd_q) begin
            state_d = IDLE;
            done_o  = 1'b1;
          end else if (RD_WAIT == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rx_d = cap_word;
        if (cnt_q == CAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_o  = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: rx_q is a plain register, so clearing it on reset is cheap and discards partial captures.
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
    end
  end

  assign ss_n_o  = (state_q == IDLE);
  assign mosi_o  = (state_q == SHIFT) && sh_q[FRAME_BITS-1];
  assign rdata_o = cap_word;

endmodule

// File: rtl/spi_ram_master.sv
// Memory-level request front end for the SPI RAM slave. Each accepted request
// becomes two frames (address then data) separated by SS_n-high gaps.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RD_WAIT    = 1
) (
  input  logic                 SCK,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int unsigned      CNT_W    = cnt_width(ADDR_SIZE, RD_WAIT, GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  phase_e               phase_q, phase_d;
  logic                 second_q, second_d;
  logic                 rw_q, rw_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ADDR_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                 eng_start;
  logic [CMD_W-1:0]     eng_cmd;
  logic [ADDR_SIZE-1:0] eng_payload;
  logic                 eng_done;
  logic [ADDR_SIZE-1:0] eng_rdata;

  // Sequencer: accept, run the address frame, gap, data frame, gap, respond.
  // The address is taken straight from req_addr into the engine's shift
  // register on the accept edge, so only rw and wdata need holding here.
  always_comb begin
    phase_d     = phase_q;
    second_d    = second_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    gap_cnt_d   = gap_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    eng_start   = 1'b0;
    eng_cmd     = WR_ADDR;
    eng_payload = '0;
    unique case (phase_q)
      PH_IDLE: begin
        if (req_valid) begin
          phase_d     = PH_FRAME;
          second_d    = 1'b0;
          rw_d        = req_rw;
          wdata_d     = req_wdata;
          eng_start   = 1'b1;
          eng_cmd     = req_rw ? RD_ADDR : WR_ADDR;
          eng_payload = req_addr;
        end
      end
      PH_FRAME: begin
        if (eng_done) begin
          phase_d   = PH_GAP;
          gap_cnt_d = '0;
          if (second_q) begin
            rsp_valid_d = 1'b1;
            if (rw_q) rsp_rdata_d = eng_rdata;
          end
        end
      end
      PH_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (second_q) begin
            phase_d = PH_IDLE;
          end else begin
            phase_d     = PH_FRAME;
            second_d    = 1'b1;
            eng_start   = 1'b1;
            eng_cmd     = rw_q ? RD_DATA : WR_DATA;
            eng_payload = rw_q ? '0 : wdata_q;
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Sequencer and response registers.
  always_ff @(posedge SCK or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_IDLE;
      second_q    <= 1'b0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      gap_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      phase_q     <= phase_d;
      second_q    <= second_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      gap_cnt_q   <= gap_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  spi_ram_frame_engine #(
    .ADDR_SIZE (ADDR_SIZE),
    .RD_WAIT   (RD_WAIT),
    .CNT_W     (CNT_W)
  ) u_engine (
    .clk       (SCK),
    .rst_n     (rst_n),
    .start_i   (eng_start),
    .cmd_i     (eng_cmd),
    .payload_i (eng_payload),
    .miso_i    (MISO),
    .ss_n_o    (SS_n),
    .mosi_o    (MOSI),
    .done_o    (eng_done),
    .rdata_o   (eng_rdata)
  );

  assign req_ready = (phase_q == PH_IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI RAM slave decodes frames and
// answers reads; a request-level memory model predicts read data; latencies
// and frame contents are derived from the frame-length rules.
module tb_spi_ram_master;

  localparam int AS        = 8;
  localparam int GAP       = 2;
  localparam int RDW       = 1;
  localparam int LOW_W     = 4 + AS;
  localparam int LOW_R     = 4 + RDW + 2 * AS;
  localparam int CAP_START = 4 + AS + RDW;

  typedef struct {
    int          len;
    logic [63:0] bits;
    int          gap;
  } frame_t;

  logic          SCK = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AS-1:0] req_addr;
  logic [AS-1:0] req_wdata;
  logic          rsp_valid;
  logic [AS-1:0] rsp_rdata;
  logic          busy;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;

  int checks = 0;
  int errors = 0;

  logic [AS-1:0] slave_mem [256];
  logic [AS-1:0] ref_mem   [256];
  logic [AS-1:0] preload0;
  logic [AS-1:0] last_rd;
  frame_t        frames [$];

  // Slave model state.
  logic [63:0]   cur_bits;
  int            cur_len;
  int            cur_gap;
  int            gap_cnt;
  logic [2:0]    cur_cmd;
  logic [AS-1:0] s_wa, s_ra;

  spi_ram_master #(
    .ADDR_SIZE  (AS),
    .GAP_CYCLES (GAP),
    .RD_WAIT    (RDW)
  ) dut (
    .SCK       (SCK),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 SCK = ~SCK;

  // Behavioural SPI RAM slave: records each SS_n-low window, answers RD_DATA.
  initial begin
    int            idx;
    logic [2:0]    cmd;
    logic [AS-1:0] pl;
    logic [AS-1:0] byte_v;
    MISO     = 1'b0;
    cur_bits = '0;
    cur_len  = 0;
    cur_gap  = 0;
    gap_cnt  = 0;
    cur_cmd  = 3'b000;
    s_wa     = '0;
    s_ra     = '0;
    forever begin
      @(negedge SCK);
      if (SS_n === 1'b0) begin
        if (cur_len == 0) cur_gap = gap_cnt;
        gap_cnt  = 0;
        cur_bits = {cur_bits[62:0], MOSI};
        cur_len++;
        if (cur_len == 4) cur_cmd = cur_bits[2:0];
        idx = cur_len - 1 - CAP_START;
        if (cur_len > 4 && cur_cmd == 3'b111 && idx >= 0 && idx < AS) begin
          byte_v = slave_mem[s_ra];
          MISO   = byte_v[AS-1-idx];
        end else begin
          MISO = 1'b0;
        end
      end else begin
        MISO = 1'b0;
        if (cur_len > 0) begin
          if (cur_len >= LOW_W) begin
            cmd = cur_bits[cur_len-2 -: 3];
            pl  = cur_bits[cur_len-5 -: AS];
            case (cmd)
              3'b000:  s_wa = pl;
              3'b001:  slave_mem[s_wa] = pl;
              3'b110:  s_ra = pl;
              default: ;
            endcase
            frames.push_back('{cur_len, cur_bits, cur_gap});
          end
          cur_len  = 0;
          cur_bits = '0;
          cur_cmd  = 3'b000;
        end
        gap_cnt++;
      end
    end
  end

  // Expected MOSI sequence: START bit, command, payload, then trailing zeros.
  function automatic logic [63:0] exp_bits(input logic [2:0] cmd,
                                           input logic [AS-1:0] pl,
                                           input int tail);
    logic [63:0] v;
    v = {52'b0, 1'b0, cmd, pl};
    return v << tail;
  endfunction

  // One request from acceptance to req_ready; chain keeps req_valid high.
  task automatic run_txn(input logic rw, input logic [AS-1:0] addr,
                         input logic [AS-1:0] wdata, input bit chain);
    int            cyc, rsp_lat, rdy_lat, rsp_cnt, rsp_cyc, rdy_cyc;
    bit            busy_bad;
    logic [AS-1:0] got, exp;
    frame_t        f1, f2;
    logic [63:0]   e2;
    int            l2;
    rsp_lat = LOW_W + GAP + (rw ? LOW_R : LOW_W);
    rdy_lat = rsp_lat + GAP;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_issue: got %b expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge SCK);
    cyc = 0; rsp_cnt = 0; rsp_cyc = -1; rdy_cyc = -1; busy_bad = 0; got = 'x;
    while (cyc < 200) begin
      @(negedge SCK);
      cyc++;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        rsp_cyc = cyc - 1;
        got     = rsp_rdata;
      end
      if (req_ready === 1'b1) begin
        rdy_cyc = cyc - 1;
        if (busy !== 1'b0) busy_bad = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
      req_rw    = 1'($urandom);
      req_addr  = AS'($urandom);
      req_wdata = AS'($urandom);
      req_valid = chain ? 1'b1 : 1'($urandom);
    end
    req_valid = chain ? 1'b1 : 1'b0;

    checks++;
    if (rdy_cyc != rdy_lat) begin
      errors++;
      $display("FAIL ready_latency: got %0d expected %0d (-1 = timeout)", rdy_cyc, rdy_lat);
    end
    checks++;
    if (rsp_cnt != 1 || rsp_cyc != rsp_lat) begin
      errors++;
      $display("FAIL rsp_valid_timing: got %0d pulses last at %0d expected 1 at %0d",
               rsp_cnt, rsp_cyc, rsp_lat);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL busy_window: got busy wrong within %0d cycles expected high until ready", rdy_lat);
    end
    if (rw) begin
      exp = ref_mem[addr];
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read_data addr %0h: got %0h expected %0h", addr, got, exp);
      end
      last_rd = exp;
    end else begin
      checks++;
      if (rsp_rdata !== last_rd) begin
        errors++;
        $display("FAIL rdata_hold: got %0h expected %0h", rsp_rdata, last_rd);
      end
      ref_mem[addr] = wdata;
    end

    checks++;
    if (frames.size() < 2) begin
      errors++;
      $display("FAIL frame_count: got %0d expected 2", frames.size());
      frames.delete();
    end else begin
      f1 = frames.pop_front();
      f2 = frames.pop_front();
      e2 = rw ? exp_bits(3'b111, '0, RDW + AS) : exp_bits(3'b001, wdata, 0);
      l2 = rw ? LOW_R : LOW_W;
      checks++;
      if (f1.len != LOW_W || f1.bits !== exp_bits(rw ? 3'b110 : 3'b000, addr, 0)) begin
        errors++;
        $display("FAIL frame1: got len %0d bits %0h expected len %0d bits %0h",
                 f1.len, f1.bits, LOW_W, exp_bits(rw ? 3'b110 : 3'b000, addr, 0));
      end
      checks++;
      if (f2.len != l2 || f2.bits !== e2 || f2.gap != GAP) begin
        errors++;
        $display("FAIL frame2: got len %0d bits %0h gap %0d expected len %0d bits %0h gap %0d",
                 f2.len, f2.bits, f2.gap, l2, e2, GAP);
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 8'h11;
    req_wdata = 8'h22;
    repeat (5) begin
      @(negedge SCK);
      if (SS_n !== 1'b1 || MOSI !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || rsp_rdata !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d bad cycles expected 0", bad);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge SCK);
    checks++;
    if (SS_n !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: got ss_n %b busy %b ready %b expected 1 0 1",
               SS_n, busy, req_ready);
    end
    frames.delete();
  endtask

  task automatic test_write_a5();
    run_txn(1'b0, 8'hA5, 8'h3C, 1'b0);
    checks++;
    if (slave_mem[8'hA5] !== 8'h3C) begin
      errors++;
      $display("FAIL slave_mem_a5: got %0h expected 3c", slave_mem[8'hA5]);
    end
  endtask

  task automatic test_read_a5();
    run_txn(1'b1, 8'hA5, 8'h00, 1'b0);
    checks++;
    if (rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL read_a5: got %0h expected 3c", rsp_rdata);
    end
  endtask

  task automatic test_read_preload();
    run_txn(1'b1, 8'h00, 8'h00, 1'b0);
    checks++;
    if (rsp_rdata !== preload0) begin
      errors++;
      $display("FAIL read_preload: got %0h expected %0h", rsp_rdata, preload0);
    end
  endtask

  task automatic test_back_to_back();
    logic [AS-1:0] a, d;
    a = 8'h40 | AS'($urandom_range(0, 15));
    d = AS'($urandom);
    run_txn(1'b0, a, d, 1'b1);
    run_txn(1'b1, a, 8'h00, 1'b1);
    run_txn(1'b0, a ^ 8'h01, ~d, 1'b1);
    run_txn(1'b1, a ^ 8'h01, 8'h00, 1'b0);
    @(negedge SCK);
  endtask

  task automatic test_random();
    logic          rw;
    logic [AS-1:0] a, d;
    bit            chain;
    for (int i = 0; i < 12; i++) begin
      rw    = 1'($urandom);
      a     = AS'($urandom_range(0, 7)) | 8'h80;
      d     = AS'($urandom);
      chain = (i == 11) ? 1'b0 : 1'($urandom);
      run_txn(rw, a, d, chain);
      if (!chain) repeat ($urandom_range(0, 3)) @(negedge SCK);
    end
  endtask

  task automatic test_reset_mid_frame();
    int mid, saw;
    mid       = LOW_W + GAP + 1 + 5;
    saw       = 0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 8'h33;
    req_wdata = 8'h99;
    @(posedge SCK);
    for (int c = 1; c <= mid; c++) begin
      @(negedge SCK);
      req_valid = 1'b0;
      if (rsp_valid === 1'b1) saw++;
    end
    checks++;
    if (SS_n !== 1'b0) begin
      errors++;
      $display("FAIL in_data_frame: got ss_n %b expected 0", SS_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (SS_n !== 1'b1 || MOSI !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
        rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL async_reset: got ss_n %b mosi %b busy %b ready %b rv %b rd %0h expected 1 0 0 1 0 0",
               SS_n, MOSI, busy, req_ready, rsp_valid, rsp_rdata);
    end
    repeat (3) begin
      @(negedge SCK);
      if (rsp_valid === 1'b1) saw++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge SCK);
      if (rsp_valid === 1'b1) saw++;
    end
    checks++;
    if (saw != 0) begin
      errors++;
      $display("FAIL no_rsp_after_abort: got %0d pulses expected 0", saw);
    end
    last_rd = '0;
    frames.delete();
    run_txn(1'b0, 8'h10, 8'h55, 1'b0);
    run_txn(1'b1, 8'h10, 8'h00, 1'b0);
    checks++;
    if (slave_mem[8'h10] !== 8'h55 || rsp_rdata !== 8'h55) begin
      errors++;
      $display("FAIL recover_write: got mem %0h rdata %0h expected 55 55",
               slave_mem[8'h10], rsp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = AS'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    preload0 = slave_mem[0];
    last_rd  = '0;
    test_reset();
    test_write_a5();
    test_read_a5();
    test_read_preload();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
